// File: rtl/ram_scanner.sv
// ram_scanner: read-side sequencer for the masked-write voice/parameter RAM.
// On each sample tick it sweeps RAM addresses 0..LAST_ADDR and streams every
// entry, tagged with its address, to the synthesis pipeline over valid/ready.
// The RAM read is combinational: o_ram_addr is driven from the registered
// pointer and the returned data is captured in the output register.
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_start           sample-tick pulse; starts a sweep when idle
//   o_ram_addr        RAM read address (= internal pointer)
//   i_ram_dout        RAM read data, combinational from o_ram_addr
//   o_data, o_addr    output entry and the address it came from
//   o_last            beat is from LAST_ADDR
//   o_valid, i_ready  output handshake
//   o_busy            sweep in progress
//   o_done            one-cycle pulse: sweep complete, all beats accepted
//   o_overrun         one-cycle pulse: i_start arrived while busy
module ram_scanner #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LAST_ADDR  = (1 << ADDR_WIDTH) - 1,
  parameter bit SKIP_ZERO  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overrun
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic                  last_nx, valid_nx, done_nx, overrun_nx;
  logic                  load_ok, at_last, skip;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      o_data    <= '0;
      o_addr    <= '0;
      o_last    <= 1'b0;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      o_data    <= data_nx;
      o_addr    <= addr_nx;
      o_last    <= last_nx;
      o_valid   <= valid_nx;
      o_done    <= done_nx;
      o_overrun <= overrun_nx;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    data_nx    = o_data;
    addr_nx    = o_addr;
    last_nx    = o_last;
    valid_nx   = o_valid;
    done_nx    = 1'b0;
    overrun_nx = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          ptr_nx   = '0;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        overrun_nx = i_start;
        if (load_ok) begin
          // A skipped entry still consumes the load slot, which retires any
          // previously accepted beat, so valid simply drops.
          if (skip) begin
            valid_nx = 1'b0;
          end else begin
            data_nx  = i_ram_dout;
            addr_nx  = ptr;
            last_nx  = at_last;
            valid_nx = 1'b1;
          end
          if (at_last) begin
            state_nx = DRAIN;
          end else begin
            ptr_nx = ptr + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        overrun_nx = i_start;
        if (load_ok) begin
          valid_nx = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Combinational outputs and qualifiers
  always_comb begin
    o_ram_addr = ptr;
    o_busy     = (state != IDLE);
    load_ok    = !o_valid || i_ready;
    at_last    = (ptr == LAST);
    skip       = SKIP_ZERO && (i_ram_dout == '0);
  end

endmodule

// File: tb/tb_ram_scanner.sv
module tb_ram_scanner;

  logic       clk;
  logic       rst_n;

  // Instance a: plain sweep, 3-bit address
  logic       start_a, ready_a;
  logic [2:0] ram_addr_a, addr_a;
  logic [7:0] ram_dout_a, data_a;
  logic       last_a, valid_a, busy_a, done_a, overrun_a;
  logic [7:0] ram_a [8];

  // Instance b: zero-skipping sweep, 3-bit address
  logic       start_b, ready_b;
  logic [2:0] ram_addr_b, addr_b;
  logic [7:0] ram_dout_b, data_b;
  logic       last_b, valid_b, busy_b, done_b, overrun_b;
  logic [7:0] ram_b [8];

  int checks   = 0;
  int failures = 0;

  assign ram_dout_a = ram_a[ram_addr_a];
  assign ram_dout_b = ram_b[ram_addr_b];

  ram_scanner #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .LAST_ADDR(7), .SKIP_ZERO(1'b0)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_a),
    .o_ram_addr(ram_addr_a), .i_ram_dout(ram_dout_a),
    .o_data(data_a), .o_addr(addr_a), .o_last(last_a), .o_valid(valid_a),
    .i_ready(ready_a), .o_busy(busy_a), .o_done(done_a), .o_overrun(overrun_a)
  );

  ram_scanner #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .LAST_ADDR(7), .SKIP_ZERO(1'b1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b),
    .o_ram_addr(ram_addr_b), .i_ram_dout(ram_dout_b),
    .o_data(data_b), .o_addr(addr_b), .o_last(last_b), .o_valid(valid_b),
    .i_ready(ready_b), .o_busy(busy_b), .o_done(done_b), .o_overrun(overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t required=finish_before_200000", $time);
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || data_a !== 8'd0 || addr_a !== 3'd0 || last_a !== 1'b0 ||
        busy_a !== 1'b0 || done_a !== 1'b0 || overrun_a !== 1'b0 || ram_addr_a !== 3'd0) begin
      failures++;
      $display("FAIL reset_a valid=%b data=%0d addr=%0d last=%b busy=%b done=%b ovr=%b ram_addr=%0d required all zero",
               valid_a, data_a, addr_a, last_a, busy_a, done_a, overrun_a, ram_addr_a);
    end
    checks++;
    if (valid_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || ram_addr_b !== 3'd0) begin
      failures++;
      $display("FAIL reset_b valid=%b busy=%b done=%b ram_addr=%0d required all zero",
               valid_b, busy_b, done_b, ram_addr_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0) begin
      failures++;
      $display("FAIL sweep_latency busy=%b valid=%b required busy=1 valid=0", busy_a, valid_a);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || data_a !== 8'(i + 1) || addr_a !== 3'(i) ||
          last_a !== (i == 7) || done_a !== 1'b0) begin
        failures++;
        $display("FAIL sweep_beat%0d valid=%b data=%0d addr=%0d last=%b done=%b required 1/%0d/%0d/%b/0",
                 i, valid_a, data_a, addr_a, last_a, done_a, i + 1, i, (i == 7));
      end
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL sweep_done done=%b valid=%b busy=%b required 1/0/0", done_a, valid_a, busy_a);
    end
    // New start in the o_done cycle must be accepted without overrun
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || overrun_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_start busy=%b ovr=%b done=%b required 1/0/0", busy_a, overrun_a, done_a);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || addr_a !== 3'(i) || data_a !== 8'(i + 1)) begin
        failures++;
        $display("FAIL back_to_back_beat%0d valid=%b addr=%0d data=%0d required 1/%0d/%0d",
                 i, valid_a, addr_a, data_a, i, i + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_done done=%b required 1", done_a);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int         beats;
    bit         seen_done;
    logic       pv, pr, pl;
    logic [7:0] pd;
    logic [2:0] pa;
    beats = 0; seen_done = 0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pa = '0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 60 && !seen_done; k++) begin
      @(negedge clk);
      if (pv && !pr) begin
        checks++;
        if (valid_a !== 1'b1 || data_a !== pd || addr_a !== pa || last_a !== pl) begin
          failures++;
          $display("FAIL stall_hold cycle=%0d valid=%b data=%0d addr=%0d last=%b required 1/%0d/%0d/%b",
                   k, valid_a, data_a, addr_a, last_a, pd, pa, pl);
        end
      end
      if (done_a === 1'b1) begin
        seen_done = 1;
      end else begin
        ready_a = (k % 2 == 0);
        if (valid_a === 1'b1 && ready_a) begin
          checks++;
          if (data_a !== 8'(beats + 1) || addr_a !== 3'(beats) || last_a !== (beats == 7)) begin
            failures++;
            $display("FAIL stall_beat%0d data=%0d addr=%0d last=%b required %0d/%0d/%b",
                     beats, data_a, addr_a, last_a, beats + 1, beats, (beats == 7));
          end
          beats++;
        end
      end
      pv = valid_a; pr = ready_a; pd = data_a; pa = addr_a; pl = last_a;
    end
    checks++;
    if (!seen_done || beats != 8) begin
      failures++;
      $display("FAIL stall_count beats=%0d done_seen=%0d required 8/1", beats, seen_done);
    end
    ready_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_skip();
    logic [7:0] exp_v;
    exp_v = 8'b0001_0010;
    ram_b[0] = 8'd0; ram_b[1] = 8'd5; ram_b[2] = 8'd0; ram_b[3] = 8'd0;
    ram_b[4] = 8'd9; ram_b[5] = 8'd0; ram_b[6] = 8'd0; ram_b[7] = 8'd0;
    ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (valid_b !== exp_v[i] || done_b !== 1'b0) begin
        failures++;
        $display("FAIL skip_valid%0d valid=%b done=%b required %b/0", i, valid_b, done_b, exp_v[i]);
      end
      if (exp_v[i]) begin
        checks++;
        if (data_b !== ((i == 1) ? 8'd5 : 8'd9) || addr_b !== 3'(i) || last_b !== 1'b0) begin
          failures++;
          $display("FAIL skip_beat%0d data=%0d addr=%0d last=%b required %0d/%0d/0",
                   i, data_b, addr_b, last_b, (i == 1) ? 5 : 9, i);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b1 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL skip_done done=%b valid=%b busy=%b required 1/0/0", done_b, valid_b, busy_b);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || addr_a !== 3'(i) || data_a !== 8'(i + 1) || overrun_a !== (i == 3)) begin
        failures++;
        $display("FAIL overrun_beat%0d valid=%b addr=%0d data=%0d ovr=%b required 1/%0d/%0d/%b",
                 i, valid_a, addr_a, data_a, overrun_a, i, i + 1, (i == 3));
      end
      start_a = (i == 2);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || overrun_a !== 1'b0) begin
      failures++;
      $display("FAIL overrun_done done=%b ovr=%b required 1/0", done_a, overrun_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      failures++;
      $display("FAIL overrun_no_restart busy=%b valid=%b required 0/0", busy_a, valid_a);
    end
  endtask

  task automatic test_reset_mid();
    ready_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || addr_a !== 3'd0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre valid=%b addr=%0d busy=%b required 1/0/1", valid_a, addr_a, busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || ram_addr_a !== 3'd0 || data_a !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_async valid=%b busy=%b done=%b ram_addr=%0d data=%0d required 0/0/0/0/0",
               valid_a, busy_a, done_a, ram_addr_a, data_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || addr_a !== 3'(i) || data_a !== 8'(i + 1)) begin
        failures++;
        $display("FAIL reset_mid_beat%0d valid=%b addr=%0d data=%0d required 1/%0d/%0d",
                 i, valid_a, addr_a, data_a, i, i + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_done done=%b required 1", done_a);
    end
    @(negedge clk);
  endtask

  task automatic test_drain_stall();
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || addr_a !== 3'(i)) begin
        failures++;
        $display("FAIL drain_beat%0d valid=%b addr=%0d required 1/%0d", i, valid_a, addr_a, i);
      end
      if (i == 7) ready_a = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || addr_a !== 3'd7 || last_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b1) begin
        failures++;
        $display("FAIL drain_hold%0d valid=%b addr=%0d last=%b done=%b busy=%b required 1/7/1/0/1",
                 k, valid_a, addr_a, last_a, done_a, busy_a);
      end
    end
    ready_a = 1'b1;
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL drain_done done=%b valid=%b busy=%b required 1/0/0", done_a, valid_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0) begin
      failures++;
      $display("FAIL drain_done_pulse done=%b required 0", done_a);
    end
  endtask

  initial begin
    start_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ram_a[i] = 8'(i + 1);
      ram_b[i] = 8'd0;
    end
    test_reset();
    test_sweep();
    test_stall();
    test_skip();
    test_overrun();
    test_reset_mid();
    test_drain_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
